stk_pipe_mc: RTL and testbench

//  Parametrised multi-context stack engine, successor to the fixed-config stack pipe.

---
 rtl/stk_mc_pkg.sv | 23 ++
 rtl/stk_mc_rr_arb.sv | 43 ++++
 rtl/stk_pipe_mc.sv | 192 +++++++++++++++++++
 tb/tb_stk_pipe_mc.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/stk_mc_pkg.sv
// Shared types for the multi-context stack engine: opcodes, response status, control state.
package stk_mc_pkg;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'd0,
    OP_POP   = 2'd1,
    OP_PEEK  = 2'd2,
    OP_CLEAR = 2'd3
  } opcode_t;

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_EMPTY = 2'd1,
    ST_FULL  = 2'd2
  } status_t;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/stk_mc_rr_arb.sv
// Round-robin arbiter: one-hot grant searching upward from a rotating pointer.
// The pointer moves to the slot after the winner whenever a grant is issued.
module stk_mc_rr_arb #(
  parameter int N = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N-1:0]                      req,
  output logic [N-1:0]                      gnt,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_idx,
  output logic                              gnt_any
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr;
  int            idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/stk_pipe_mc.sv
// Multi-context stack engine: ENGS_N linked LIFOs sharing one DEPTH-entry pool plus a free list.
// Single-cycle commands with registered responses; CLEAR unlinks one entry per cycle.
module stk_pipe_mc
  import stk_mc_pkg::*;
#(
  parameter int ENGS_N = 4,
  parameter int DEPTH  = 16,
  parameter int W      = 128
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ENGS_N-1:0]              i_cmd_vld,
  input  logic [ENGS_N-1:0][1:0]         i_cmd_opcode,
  input  logic [ENGS_N-1:0][W-1:0]       i_cmd_dat,
  output logic [ENGS_N-1:0]              o_cmd_ack,
  output logic [ENGS_N-1:0]              o_rsp_vld,
  output logic [W-1:0]                   o_rsp_dat,
  output logic [1:0]                     o_rsp_status,
  output logic                           o_busy,
  output logic [$clog2(DEPTH+1)-1:0]     o_free_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int EW    = (ENGS_N > 1) ? $clog2(ENGS_N) : 1;

  state_t              state;
  logic [PTR_W-1:0]    init_idx;
  logic [PTR_W-1:0]    free_head;
  logic [CNT_W-1:0]    free_cnt;
  logic [EW-1:0]       clr_eng;

  logic [W-1:0]        dat_mem [DEPTH];
  logic [PTR_W-1:0]    nxt_mem [DEPTH];

  logic [ENGS_N-1:0]   head_vld;
  logic [PTR_W-1:0]    head_ptr [ENGS_N];
  logic [CNT_W-1:0]    cnt      [ENGS_N];

  logic [ENGS_N-1:0]   rsp_vld;
  logic [W-1:0]        rsp_dat;
  status_t             rsp_status;

  logic [ENGS_N-1:0]   req;
  logic [ENGS_N-1:0]   gnt;
  logic [EW-1:0]       gnt_idx;
  logic                gnt_any;

  logic [EW-1:0]       sel;
  opcode_t             op;
  logic [PTR_W-1:0]    sel_head;
  logic                do_push;
  logic                do_unlink;
  logic                nxt_we;
  logic [PTR_W-1:0]    nxt_wa;
  logic [PTR_W-1:0]    nxt_wd;

  assign req = i_cmd_vld & {ENGS_N{state == S_IDLE}};

  stk_mc_rr_arb #(.N(ENGS_N)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // During CLEAR the engine being drained owns the datapath instead of the arbiter winner.
  assign sel       = (state == S_CLEAR) ? clr_eng : gnt_idx;
  assign op        = opcode_t'(i_cmd_opcode[sel]);
  assign sel_head  = head_ptr[sel];
  assign do_push   = (state == S_IDLE) && gnt_any && (op == OP_PUSH) && (free_cnt != '0);
  assign do_unlink = (state == S_CLEAR) ||
                     ((state == S_IDLE) && gnt_any && (op == OP_POP) && head_vld[sel]);

  assign o_cmd_ack    = gnt;
  assign o_rsp_vld    = rsp_vld;
  assign o_rsp_dat    = rsp_dat;
  assign o_rsp_status = rsp_status;
  assign o_busy       = (state != S_IDLE);
  assign o_free_cnt   = free_cnt;

  always_comb begin
    nxt_we = 1'b0;
    nxt_wa = '0;
    nxt_wd = '0;
    if (state == S_INIT) begin
      // The last index wraps to 0, which serves as the null link.
      nxt_we = 1'b1;
      nxt_wa = init_idx;
      nxt_wd = init_idx + 1'b1;
    end else if (do_push) begin
      nxt_we = 1'b1;
      nxt_wa = free_head;
      nxt_wd = sel_head;
    end else if (do_unlink) begin
      nxt_we = 1'b1;
      nxt_wa = sel_head;
      nxt_wd = free_head;
    end
  end

  always_ff @(posedge clk) begin
    if (nxt_we)  nxt_mem[nxt_wa]   <= nxt_wd;
    if (do_push) dat_mem[free_head] <= i_cmd_dat[sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INIT;
      init_idx   <= '0;
      free_head  <= '0;
      free_cnt   <= '0;
      clr_eng    <= '0;
      head_vld   <= '0;
      rsp_vld    <= '0;
      rsp_dat    <= '0;
      rsp_status <= ST_OK;
      for (int e = 0; e < ENGS_N; e++) begin
        head_ptr[e] <= '0;
        cnt[e]      <= '0;
      end
    end else begin
      rsp_vld    <= '0;
      rsp_dat    <= '0;
      rsp_status <= ST_OK;

      unique case (state)
        S_INIT: begin
          free_cnt <= free_cnt + 1'b1;
          init_idx <= init_idx + 1'b1;
          if (init_idx == PTR_W'(DEPTH - 1)) begin
            free_head <= '0;
            state     <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (gnt_any) begin
            rsp_vld <= gnt;
            unique case (op)
              OP_PUSH: if (!do_push) rsp_status <= ST_FULL;
              OP_POP, OP_PEEK: begin
                if (head_vld[sel]) rsp_dat    <= dat_mem[sel_head];
                else               rsp_status <= ST_EMPTY;
              end
              OP_CLEAR: begin
                // Non-empty clears answer only once the last entry is unlinked.
                if (head_vld[sel]) begin
                  rsp_vld <= '0;
                  clr_eng <= sel;
                  state   <= S_CLEAR;
                end
              end
            endcase
          end
        end
        S_CLEAR: begin
          if (cnt[clr_eng] == CNT_W'(1)) begin
            rsp_vld <= ENGS_N'(1) << clr_eng;
            state   <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase

      if (do_push) begin
        free_head     <= nxt_mem[free_head];
        head_ptr[sel] <= free_head;
        head_vld[sel] <= 1'b1;
        cnt[sel]      <= cnt[sel] + 1'b1;
        free_cnt      <= free_cnt - 1'b1;
      end
      if (do_unlink) begin
        head_ptr[sel] <= nxt_mem[sel_head];
        head_vld[sel] <= (cnt[sel] != CNT_W'(1));
        free_head     <= sel_head;
        cnt[sel]      <= cnt[sel] - 1'b1;
        free_cnt      <= free_cnt + 1'b1;
      end
    end
  end

  logic [31:0] used_total;
  always_comb begin
    used_total = 32'(free_cnt);
    for (int e = 0; e < ENGS_N; e++) used_total = used_total + 32'(cnt[e]);
  end

  a_conserve: assert property (@(posedge clk) disable iff (rst)
    (state != S_INIT) |-> (used_total == 32'(DEPTH)));

endmodule

// File: tb/tb_stk_pipe_mc.sv
// Directed bench for stk_pipe_mc: init ramp, LIFO order, full/empty, arbitration, CLEAR, reset abort.
module tb_stk_pipe_mc;
  import stk_mc_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           vld;
  logic [3:0][1:0]      opc;
  logic [3:0][127:0]    dat;
  logic [3:0]           ack;
  logic [3:0]           rsp_vld;
  logic [127:0]         rsp_dat;
  logic [1:0]           rsp_status;
  logic                 busy;
  logic [4:0]           free_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stk_pipe_mc #(.ENGS_N(4), .DEPTH(16), .W(128)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_cmd_vld    (vld),
    .i_cmd_opcode (opc),
    .i_cmd_dat    (dat),
    .o_cmd_ack    (ack),
    .o_rsp_vld    (rsp_vld),
    .o_rsp_dat    (rsp_dat),
    .o_rsp_status (rsp_status),
    .o_busy       (busy),
    .o_free_cnt   (free_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command from a negedge, check the ack, then the response one cycle later.
  task automatic do_cmd(input string tag, input int e, input logic [1:0] op,
                        input logic [127:0] d, input logic [1:0] est,
                        input logic [127:0] edat, input int efree);
    logic [3:0] oh;
    oh      = 4'b0001 << e;
    vld     = '0;
    vld[e]  = 1'b1;
    opc[e]  = op;
    dat[e]  = d;
    #1;
    chk({tag, "_ack"}, 128'(ack), 128'(oh));
    @(negedge clk);
    vld = '0;
    #1;
    chk({tag, "_rsp_vld"}, 128'(rsp_vld), 128'(oh));
    chk({tag, "_status"},  128'(rsp_status), 128'(est));
    chk({tag, "_dat"},     rsp_dat, edat);
    chk({tag, "_free"},    128'(free_cnt), 128'(efree));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    vld = '0;
    opc = '0;
    dat = '0;

    // 1: reset state, INIT ramp, acks blocked until IDLE
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy",    128'(busy), 128'(1));
    chk("rst_free",    128'(free_cnt), 128'(0));
    chk("rst_rsp_vld", 128'(rsp_vld), 128'(0));
    chk("rst_rsp_dat", rsp_dat, 128'(0));
    chk("rst_status",  128'(rsp_status), 128'(ST_OK));
    rst    = 1'b0;
    vld[0] = 1'b1;
    opc[0] = OP_PEEK;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      #1;
      chk("init_free", 128'(free_cnt), 128'(i));
      chk("init_busy", 128'(busy), 128'((i < 16) ? 1 : 0));
      chk("init_ack",  128'(ack), 128'((i < 16) ? 0 : 1));
    end
    @(negedge clk);
    vld = '0;
    #1;
    chk("exit_rsp_vld", 128'(rsp_vld), 128'(1));
    chk("exit_status",  128'(rsp_status), 128'(ST_EMPTY));

    // 2: LIFO order on engine 0
    do_cmd("t2_push_a", 0, OP_PUSH, 128'hA, ST_OK, 128'h0, 15);
    do_cmd("t2_push_b", 0, OP_PUSH, 128'hB, ST_OK, 128'h0, 14);
    do_cmd("t2_pop_b",  0, OP_POP,  128'h0, ST_OK, 128'hB, 15);
    do_cmd("t2_pop_a",  0, OP_POP,  128'h0, ST_OK, 128'hA, 16);
    do_cmd("t2_pop_e",  0, OP_POP,  128'h0, ST_EMPTY, 128'h0, 16);

    // 3: fill pool across engines 1/2, overflow, peek, drain
    for (int i = 0; i < 16; i++)
      do_cmd("t3_push", (i % 2 == 1) ? 2 : 1, OP_PUSH, 128'(32'h100 + i), ST_OK, 128'h0, 15 - i);
    do_cmd("t3_full",  1, OP_PUSH, 128'h1FF, ST_FULL, 128'h0, 0);
    do_cmd("t3_peek",  2, OP_PEEK, 128'h0, ST_OK, 128'h10F, 0);
    do_cmd("t3_pop2a", 2, OP_POP,  128'h0, ST_OK, 128'h10F, 1);
    do_cmd("t3_pop2b", 2, OP_POP,  128'h0, ST_OK, 128'h10D, 2);
    for (int j = 0; j < 8; j++)
      do_cmd("t3_drain1", 1, OP_POP, 128'h0, ST_OK, 128'(32'h10E - 2 * j), 3 + j);
    for (int j = 0; j < 6; j++)
      do_cmd("t3_drain2", 2, OP_POP, 128'h0, ST_OK, 128'(32'h10B - 2 * j), 11 + j);
    do_cmd("t4_align", 3, OP_PEEK, 128'h0, ST_EMPTY, 128'h0, 16);

    // 4: all engines requesting every cycle
    for (int k = 0; k < 8; k++) begin
      vld = 4'hF;
      for (int e = 0; e < 4; e++) opc[e] = OP_PEEK;
      #1;
      chk("t4_ack", 128'(ack), 128'(4'b0001 << (k % 4)));
      if (k > 0) chk("t4_rsp_vld", 128'(rsp_vld), 128'(4'b0001 << ((k - 1) % 4)));
      @(negedge clk);
    end
    vld = '0;
    #1;
    chk("t4_last_rsp", 128'(rsp_vld), 128'(4'b1000));

    // 5: CLEAR of a 5-deep engine 3
    do_cmd("t5_push0", 0, OP_PUSH, 128'h77, ST_OK, 128'h0, 15);
    do_cmd("t5_push1", 1, OP_PUSH, 128'h88, ST_OK, 128'h0, 14);
    for (int i = 0; i < 5; i++)
      do_cmd("t5_push3", 3, OP_PUSH, 128'(32'h30 + i), ST_OK, 128'h0, 13 - i);
    vld    = '0;
    vld[3] = 1'b1;
    opc[3] = OP_CLEAR;
    #1;
    chk("t5_clr_ack", 128'(ack), 128'(4'b1000));
    @(negedge clk);
    vld    = '0;
    vld[0] = 1'b1;
    opc[0] = OP_PEEK;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      #1;
      chk("t5_busy",    128'(busy), 128'(1));
      chk("t5_ack_blk", 128'(ack), 128'(0));
      chk("t5_no_rsp",  128'(rsp_vld), 128'(0));
      chk("t5_free",    128'(free_cnt), 128'(9 + j));
    end
    @(negedge clk);
    #1;
    chk("t5_done_busy",   128'(busy), 128'(0));
    chk("t5_done_free",   128'(free_cnt), 128'(14));
    chk("t5_done_rsp",    128'(rsp_vld), 128'(4'b1000));
    chk("t5_done_status", 128'(rsp_status), 128'(ST_OK));
    chk("t5_next_ack",    128'(ack), 128'(4'b0001));
    @(negedge clk);
    vld = '0;
    #1;
    chk("t5_peek_rsp", 128'(rsp_vld), 128'(4'b0001));
    chk("t5_peek_dat", rsp_dat, 128'h77);
    do_cmd("t5_pop0", 0, OP_POP, 128'h0, ST_OK, 128'h77, 15);
    do_cmd("t5_pop1", 1, OP_POP, 128'h0, ST_OK, 128'h88, 16);
    do_cmd("t5_pop3", 3, OP_POP, 128'h0, ST_EMPTY, 128'h0, 16);

    // 6: reset in the middle of a CLEAR
    do_cmd("t6_push1", 1, OP_PUSH, 128'h99, ST_OK, 128'h0, 15);
    for (int i = 0; i < 5; i++)
      do_cmd("t6_push3", 3, OP_PUSH, 128'(32'h40 + i), ST_OK, 128'h0, 14 - i);
    vld    = '0;
    vld[3] = 1'b1;
    opc[3] = OP_CLEAR;
    #1;
    chk("t6_clr_ack", 128'(ack), 128'(4'b1000));
    @(negedge clk);
    vld = '0;
    #1;
    chk("t6_busy", 128'(busy), 128'(1));
    @(negedge clk);
    #1;
    chk("t6_free_mid", 128'(free_cnt), 128'(11));
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("t6_rst_free", 128'(free_cnt), 128'(0));
    chk("t6_rst_rsp",  128'(rsp_vld), 128'(0));
    chk("t6_rst_busy", 128'(busy), 128'(1));
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      #1;
      chk("t6_init_rsp", 128'(rsp_vld), 128'(0));
    end
    chk("t6_init_busy", 128'(busy), 128'(0));
    chk("t6_init_free", 128'(free_cnt), 128'(16));
    for (int e = 0; e < 4; e++)
      do_cmd("t6_pop_empty", e, OP_POP, 128'h0, ST_EMPTY, 128'h0, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
